// File: rtl/stream_reduce_sum.sv
// Terminal stream reduction: sums data elements until EOS, then emits the sum
// followed by an EOS token on the output stream.
module stream_reduce_sum #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           CNT_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data_field0,
    input  logic                  in0_data_field1,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out0_data_field0,
    output logic                  out0_data_field1,
    output logic [CNT_WIDTH-1:0]  elem_count
);

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        EMIT_SUM = 2'd1,
        EMIT_EOS = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] acc;
    logic                  live;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = in0_valid && in0_ready;
    assign out_fire = out0_valid && out0_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:    if (in_fire && in0_data_field1) state_next = EMIT_SUM;
            EMIT_SUM: if (out_fire) state_next = EMIT_EOS;
            EMIT_EOS: if (out_fire) state_next = ACCUM;
            default:  state_next = ACCUM;
        endcase
    end

    // live holds in0_ready low while reset is asserted without a comb path from reset
    always_comb begin
        in0_ready        = 1'b0;
        out0_valid       = 1'b0;
        out0_data_field0 = '0;
        out0_data_field1 = 1'b0;
        case (state)
            ACCUM: in0_ready = live;
            EMIT_SUM: begin
                out0_valid       = 1'b1;
                out0_data_field0 = acc;
            end
            EMIT_EOS: begin
                out0_valid       = 1'b1;
                out0_data_field1 = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live       <= 1'b0;
            acc        <= INIT;
            elem_count <= '0;
        end else begin
            live <= 1'b1;
            if (state == ACCUM && in_fire && !in0_data_field1) begin
                acc <= acc + in0_data_field0;
                if (elem_count != '1) elem_count <= elem_count + CNT_ONE;
            end
            if (state == EMIT_EOS && out_fire) begin
                acc        <= INIT;
                elem_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stream_reduce_sum.sv
// Directed scoreboard bench for stream_reduce_sum: expected tokens are queued
// when EOS is accepted and compared as the DUT transfers them.
module tb_stream_reduce_sum;

    logic        clock = 1'b0;
    logic        reset;
    logic        in0_valid;
    logic        in0_ready;
    logic [63:0] in0_data_field0;
    logic        in0_data_field1;
    logic        out0_valid;
    logic        out0_ready;
    logic [63:0] out0_data_field0;
    logic        out0_data_field1;
    logic [31:0] elem_count;

    stream_reduce_sum #(
        .DATA_WIDTH(64),
        .CNT_WIDTH (32),
        .INIT      (64'd0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in0_valid       (in0_valid),
        .in0_ready       (in0_ready),
        .in0_data_field0 (in0_data_field0),
        .in0_data_field1 (in0_data_field1),
        .out0_valid      (out0_valid),
        .out0_ready      (out0_ready),
        .out0_data_field0(out0_data_field0),
        .out0_data_field1(out0_data_field1),
        .elem_count      (elem_count)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [64:0] exp_q[$];
    logic [63:0] m_sum;
    logic        in_acc;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge (they transfer at the next posedge).
    task automatic cycle();
        logic [64:0] e;
        @(negedge clock);
        in_acc = reset && in0_valid && in0_ready;
        if (in_acc) begin
            if (!in0_data_field1) begin
                m_sum = m_sum + in0_data_field0;
            end else begin
                exp_q.push_back({m_sum, 1'b0});
                exp_q.push_back({64'd0, 1'b1});
                m_sum = 64'd0;
            end
        end
        if (reset && out0_valid && out0_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_token", {out0_data_field0, out0_data_field1}, 65'h1_ffff_ffff_ffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("out_token", {out0_data_field0, out0_data_field1}, e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic eos);
        logic got;
        got             = 1'b0;
        in0_valid       = 1'b1;
        in0_data_field0 = d;
        in0_data_field1 = eos;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = in_acc;
        end
        check("send_accept", {64'd0, got}, 65'd1);
        in0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        check("drain_done", 65'(exp_q.size()), 65'd0);
    endtask

    initial begin
        m_sum           = 64'd0;
        reset           = 1'b0;
        in0_valid       = 1'b0;
        in0_data_field0 = 64'd0;
        in0_data_field1 = 1'b0;
        out0_ready      = 1'b1;
        #2;
        check("rst_in0_ready", {64'd0, in0_ready}, 65'd0);
        check("rst_out0_valid", {64'd0, out0_valid}, 65'd0);
        check("rst_out0_data", {out0_data_field0, out0_data_field1}, 65'd0);
        check("rst_elem_count", 65'(elem_count), 65'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle();
        check("post_rst_in0_ready", {64'd0, in0_ready}, 65'd1);

        // 1..5 then EOS
        for (int i = 1; i <= 5; i++) send(64'(i), 1'b0);
        send(64'd0, 1'b1);
        check("t1_count_emit", 65'(elem_count), 65'd5);
        check("t1_valid", {64'd0, out0_valid}, 65'd1);
        drain();
        check("t1_count_after", 65'(elem_count), 65'd0);

        // empty stream
        send(64'd0, 1'b1);
        check("t2_count", 65'(elem_count), 65'd0);
        drain();
        check("t2_count_after", 65'(elem_count), 65'd0);

        // wrap-around
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd2, 1'b0);
        send(64'd0, 1'b1);
        check("t3_count", 65'(elem_count), 65'd2);
        check("t3_sum", {out0_data_field0, out0_data_field1}, {64'd1, 1'b0});
        drain();

        // downstream stall
        send(64'd10, 1'b0);
        send(64'd20, 1'b0);
        out0_ready = 1'b0;
        send(64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_valid", {64'd0, out0_valid}, 65'd1);
            check("t4_stall_data", {out0_data_field0, out0_data_field1}, {64'd30, 1'b0});
            check("t4_stall_in0_ready", {64'd0, in0_ready}, 65'd0);
            cycle();
        end
        out0_ready = 1'b1;
        drain();

        // back-to-back streams, in0_valid held high across the boundary
        send(64'd7, 1'b0);
        send(64'd8, 1'b0);
        send(64'd0, 1'b1);
        send(64'd100, 1'b0);
        check("t5_count2", 65'(elem_count), 65'd1);
        send(64'd0, 1'b1);
        drain();

        // reset mid-stream
        send(64'd5, 1'b0);
        send(64'd6, 1'b0);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", {64'd0, out0_valid}, 65'd0);
        check("t6_rst_count", 65'(elem_count), 65'd0);
        check("t6_rst_in0_ready", {64'd0, in0_ready}, 65'd0);
        m_sum = 64'd0;
        cycle();
        check("t6_rst_hold_count", 65'(elem_count), 65'd0);
        reset = 1'b1;
        send(64'd1, 1'b0);
        send(64'd0, 1'b1);
        check("t6_sum", {out0_data_field0, out0_data_field1}, {64'd1, 1'b0});
        drain();
        cycle();
        check("final_queue_empty", 65'(exp_q.size()), 65'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_reduce_sum.md
Name: stream_reduce_sum

Overview:
- Downstream consumer of a stream-dialect element stream: the 64-bit payload in field0 plus the EOS flag in field1.
- Accumulates the sum and the count of all elements until EOS.
- Then emits a one-element result stream: the sum, followed by an EOS token.
- Used as the terminal reduction stage after generated stream pipelines, and as a checkable sink in integration tests.

Parameters:
- DATA_WIDTH, 64: width of the in0/out0 field0 payload.
- CNT_WIDTH, 32: width of the element counter.
- INIT, 0: accumulator value at reset and at the start of each stream (DATA_WIDTH bits).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clock.
- in0_valid  input  1  upstream element valid.
- in0_ready  output  1  block accepts an in0 element.
- in0_data_field0  input  DATA_WIDTH  element payload.
- in0_data_field1  input  1  1 = EOS token (field0 ignored), 0 = data element.
- out0_valid  output  1  result/EOS token valid.
- out0_ready  input  1  downstream accepts an out0 token.
- out0_data_field0  output  DATA_WIDTH  sum (result token), 0 on EOS token.
- out0_data_field1  output  1  0 = result token, 1 = EOS token.
- elem_count  output  CNT_WIDTH  data elements accepted in the current stream.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready.
  - out0 is valid/ready: once out0_valid rises, out0_valid and out0_data_* stay stable until the transfer.
  - in0_ready depends only on state, never combinationally on in0_valid.
- All outputs are registered or decoded from the state register. There is no combinational path from in0 to out0 or from out0_ready to in0_ready.
- Reset values: state=ACCUM, acc=INIT, elem_count=0, in0_ready=1 after reset deasserts (0 while reset is low), out0_valid=0, out0_data_field0=0, out0_data_field1=0.
- FSM states:
  - ACCUM:
    - in0_ready=1, out0_valid=0.
    - On a data transfer (field1=0): acc <= acc + field0, modulo 2^DATA_WIDTH (wraps silently). elem_count <= elem_count+1, saturating at all-ones.
    - On an EOS transfer (field1=1): acc and elem_count are unchanged; go to EMIT_SUM.
  - EMIT_SUM:
    - in0_ready=0, out0_valid=1, field0=acc, field1=0.
    - On an out0 transfer, go to EMIT_EOS.
  - EMIT_EOS:
    - in0_ready=0, out0_valid=1, field0=0, field1=1.
    - On an out0 transfer: acc <= INIT, elem_count <= 0, go to ACCUM.
- Latency: EOS accepted at edge N -> sum token valid in the cycle after edge N.
  - With out0_ready held 1, the EOS token follows at edge N+1.
  - ACCUM is re-entered at edge N+2; the next in0 element can be accepted at edge N+3.
- Empty stream (EOS is the first token): emits sum=INIT, then EOS; elem_count reads 0.
- elem_count remains valid through EMIT_SUM/EMIT_EOS and clears only on the EOS transfer.
- Reset low mid-operation: immediate return to reset values; any partial sum is discarded and no partial token is emitted.
- Back-to-back streams with in0_valid held high: no element is lost. in0 is simply not accepted until ACCUM.

Test Plan:
- Stream 1,2,3,4,5 then EOS, out0_ready=1 -> out0 emits (field0=15, field1=0) then (0,1); elem_count=5 during emission, 0 afterwards.
- EOS only -> out0 emits (0,0) then (0,1); elem_count=0 throughout.
- Elements 0xFFFF_FFFF_FFFF_FFFF and 2 then EOS -> sum token field0=1 (wrap), elem_count=2.
- Stream 10,20 then EOS with out0_ready=0 for 3 cycles -> out0_valid=1 with field0=30 held stable for all 3 cycles; in0_ready=0; sum transfers on the first ready cycle, then EOS.
- Stream 7,8 then EOS, immediately followed by stream 100 then EOS, in0_valid held high -> outputs (15,0),(0,1),(100,0),(0,1); the second stream's accumulator starts from INIT.
- Reset pulled low after elements 5 and 6, then released; feed 1 then EOS -> output (1,0),(0,1); out0_valid=0 and elem_count=0 while reset is low.
